weight_stationary_mmu: RTL

Parametrised next-generation matrix multiply unit for the TPU datapath. Accepts unskewed row vectors over a valid/ready handshake, skews them internally, and runs them through a MATRIX_WIDTH x MATRIX_WIDTH weight-stationary systolic array. Outputs are deskewed into aligned result rows. Weights are double-buffered (shadow/active) so the next matrix can load while the current one computes; activation is deferred safely until in-flight vectors drain.

---
 rtl/tpu_pkg.sv | 11 +
 rtl/mmu_pe.sv | 41 ++++
 rtl/weight_stationary_mmu.sv | 99 +++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared TPU datapath types and matrix-unit helpers
package tpu_pkg;
  typedef logic [7:0] byte_type;
  typedef logic [31:0] word_type;
  localparam int MMU_N = 4;
  typedef byte_type [MMU_N-1:0] mmu_vec_t;
  typedef word_type [MMU_N-1:0] mmu_acc_vec_t;
  function automatic int mmu_latency(input int n);
    return 2 * n;
  endfunction
endpackage

// File: rtl/mmu_pe.sv
// mmu_pe: weight-stationary MAC cell with registered data-right and sum-down passthrough
module mmu_pe import tpu_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic                  ws_i,
  input  logic [DATA_WIDTH:0]   a_i,
  input  logic [ACC_WIDTH-1:0]  s_i,
  output logic [DATA_WIDTH:0]   a_o,
  output logic [ACC_WIDTH-1:0]  s_o
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW + 2;
  logic [DW-1:0] w_q;
  logic ws_q;
  logic [PW-1:0] ea, ew, p;
  assign ea = {{(DW + 2){a_i[DW] & a_i[DW-1]}}, a_i[DW-1:0]};
  assign ew = {{(DW + 2){ws_q & w_q[DW-1]}}, w_q};
  assign p = ea * ew;
  always_ff @(posedge clk)
    if (rst) begin
      w_q <= '0;
      ws_q <= 1'b0;
      a_o <= '0;
      s_o <= '0;
    end else begin
      if (load_i) begin
        w_q <= w_i;
        ws_q <= ws_i;
      end
      if (enable) begin
        a_o <= a_i;
        s_o <= s_i + {{(ACC_WIDTH - PW){p[PW-1]}}, p};
      end
    end
endmodule

// File: rtl/weight_stationary_mmu.sv
// weight_stationary_mmu: skewed systolic matrix multiply with double-buffered weights and deferred activation
module weight_stationary_mmu import tpu_pkg::*; #(
  parameter int MATRIX_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0] weight_data,
  input  logic [$clog2(MATRIX_WIDTH)-1:0]    weight_addr,
  input  logic                               weight_signed,
  input  logic                               load_weight,
  input  logic                               activate_weight,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0] in_data,
  input  logic                               in_signed,
  output logic                               out_valid,
  output logic [MATRIX_WIDTH*ACC_WIDTH-1:0]  out_data,
  output logic                               busy
);
  localparam int N = MATRIX_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int L = mmu_latency(MATRIX_WIDTH);
  logic [N*DW-1:0] sh_q [N];
  logic [N*DW-1:0] sh_d [N];
  logic [N-1:0] shs_q, shs_d;
  logic pend_q, cp;
  logic [L:0] vld_q;
  logic [DW:0] a_w [N][N+1];
  logic [AW-1:0] s_w [N+1][N];
  assign busy = |vld_q[L-1:0];
  assign out_valid = vld_q[L];
  assign in_ready = enable & ~pend_q & ~(activate_weight & busy);
  assign cp = (activate_weight | pend_q) & ~busy;
  always_comb begin
    sh_d = sh_q;
    shs_d = shs_q;
    if (load_weight) begin
      sh_d[weight_addr] = weight_data;
      shs_d[weight_addr] = weight_signed;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      sh_q <= '{default: '0};
      shs_q <= '0;
      pend_q <= 1'b0;
      vld_q <= '0;
    end else begin
      sh_q <= sh_d;
      shs_q <= shs_d;
      pend_q <= (pend_q | activate_weight) & busy;
      if (enable) vld_q <= {vld_q[L-1:0], in_valid & in_ready};
    end
  for (genvar k = 0; k < N; k++) begin : g_sk
    logic [DW:0] d_q [k+1];
    always_ff @(posedge clk)
      if (rst) begin
        for (int i = 0; i <= k; i++) d_q[i] <= '0;
      end else if (enable) begin
        d_q[0] <= {in_signed, in_data[k*DW +: DW]};
        for (int i = 1; i <= k; i++) d_q[i] <= d_q[i-1];
      end
    assign a_w[k][0] = d_q[k];
  end
  for (genvar j = 0; j < N; j++) begin : g_top
    assign s_w[0][j] = '0;
  end
  for (genvar k = 0; k < N; k++) begin : g_r
    for (genvar j = 0; j < N; j++) begin : g_c
      mmu_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) u_pe (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load_i (cp),
        .w_i    (sh_d[k][j*DW +: DW]),
        .ws_i   (shs_d[k]),
        .a_i    (a_w[k][j]),
        .s_i    (s_w[k][j]),
        .a_o    (a_w[k][j+1]),
        .s_o    (s_w[k+1][j])
      );
    end
  end
  for (genvar j = 0; j < N; j++) begin : g_ds
    logic [AW-1:0] c_q [N-j];
    always_ff @(posedge clk)
      if (rst) begin
        for (int i = 0; i < N - j; i++) c_q[i] <= '0;
      end else if (enable) begin
        c_q[0] <= s_w[N][j];
        for (int i = 1; i < N - j; i++) c_q[i] <= c_q[i-1];
      end
    assign out_data[j*AW +: AW] = c_q[N-j-1];
  end
endmodule
